// File: rtl/thunderbird_lamp_monitor.sv
// -----------------------------------------------------------------------------
// thunderbird_lamp_monitor
//
// Receive-side checker for the Thunderbird tail-lamp sequencer outputs. Each
// 3-lamp bank is tracked by a 4-position FSM (P0..P3) that follows the sweep.
// The checker counts completed sweeps, decodes the signalling mode, and flags
// any code or transition the sequencer can never legally produce.
//
// Strobe semantics: there is no valid/ready handshake. 'sample' is a
// qualifier: on a rising edge with sample=1 both banks are evaluated; with
// sample=0 all tracked state holds and the pulse outputs are 0. 'clr' acts on
// every edge regardless of 'sample'.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   sample     evaluate lamp inputs this cycle
//   clr        synchronous clear of sweep counters and sticky error flags
//   lamp_l     left bank  (legal 000,001,011,111 = positions 0..3)
//   lamp_r     right bank (legal 000,100,110,111 = positions 0..3)
//   pos_l/r    tracker FSM state (last accepted position)
//   mode       00 idle, 01 left, 10 right, 11 hazard
//   sweep_l/r  one-cycle pulse on a completed sweep (P3 -> P0)
//   cnt_l/r    saturating completed-sweep counters
//   err_l/r    sticky error flags
//   err_pulse  one-cycle pulse on any new error on either bank
// -----------------------------------------------------------------------------
module thunderbird_lamp_monitor #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample,
    input  logic             clr,
    input  logic [2:0]       lamp_l,
    input  logic [2:0]       lamp_r,
    output logic [1:0]       pos_l,
    output logic [1:0]       pos_r,
    output logic [1:0]       mode,
    output logic             sweep_l,
    output logic             sweep_r,
    output logic [CNT_W-1:0] cnt_l,
    output logic [CNT_W-1:0] cnt_r,
    output logic             err_l,
    output logic             err_r,
    output logic             err_pulse
);

    localparam logic [1:0] P0 = 2'd0;
    localparam logic [1:0] P1 = 2'd1;
    localparam logic [1:0] P2 = 2'd2;
    localparam logic [1:0] P3 = 2'd3;

    // Decoders return {valid, position}. The two banks sweep in mirror order.
    function automatic logic [2:0] decode_l(input logic [2:0] code);
        case (code)
            3'b000:  return {1'b1, P0};
            3'b001:  return {1'b1, P1};
            3'b011:  return {1'b1, P2};
            3'b111:  return {1'b1, P3};
            default: return {1'b0, P0};
        endcase
    endfunction

    function automatic logic [2:0] decode_r(input logic [2:0] code);
        case (code)
            3'b000:  return {1'b1, P0};
            3'b100:  return {1'b1, P1};
            3'b110:  return {1'b1, P2};
            3'b111:  return {1'b1, P3};
            default: return {1'b0, P0};
        endcase
    endfunction

    // Tracker step: returns {next_state, sweep, err}.
    // Dropping to P0 is always legal; only P3 -> P0 is a completed sweep.
    // An illegal transition with a legal code resyncs to the observed
    // position; an illegal code forces P0.
    function automatic logic [3:0] track(input logic [1:0] cur,
                                         input logic [2:0] dec);
        logic       valid;
        logic [1:0] n;
        valid = dec[2];
        n     = dec[1:0];
        if (!valid)
            return {P0, 1'b0, 1'b1};
        else if (n == P0)
            return {P0, (cur == P3), 1'b0};
        else if ((cur != P3) && (n == cur + 2'd1))
            return {n, 1'b0, 1'b0};
        else
            return {n, 1'b0, 1'b1};
    endfunction

    logic [1:0] state_l, state_r;
    logic [3:0] trk_l, trk_r;
    logic       ev_sweep_l, ev_sweep_r, ev_err_l, ev_err_r;

    assign trk_l      = track(state_l, decode_l(lamp_l));
    assign trk_r      = track(state_r, decode_r(lamp_r));
    assign ev_sweep_l = sample & trk_l[1];
    assign ev_sweep_r = sample & trk_r[1];
    assign ev_err_l   = sample & trk_l[0];
    assign ev_err_r   = sample & trk_r[0];

    // Clear is applied first so that a sample in the same cycle lands on
    // top of the cleared values.
    logic [CNT_W-1:0] cnt_base_l, cnt_base_r, cnt_nxt_l, cnt_nxt_r;
    logic             err_nxt_l, err_nxt_r;

    always_comb begin
        cnt_base_l = clr ? '0 : cnt_l;
        cnt_base_r = clr ? '0 : cnt_r;
        cnt_nxt_l  = cnt_base_l;
        cnt_nxt_r  = cnt_base_r;
        if (ev_sweep_l && (cnt_base_l != '1))
            cnt_nxt_l = cnt_base_l + CNT_W'(1);
        if (ev_sweep_r && (cnt_base_r != '1))
            cnt_nxt_r = cnt_base_r + CNT_W'(1);
        err_nxt_l = (clr ? 1'b0 : err_l) | ev_err_l;
        err_nxt_r = (clr ? 1'b0 : err_r) | ev_err_r;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_l   <= P0;
            state_r   <= P0;
            mode      <= 2'b00;
            cnt_l     <= '0;
            cnt_r     <= '0;
            err_l     <= 1'b0;
            err_r     <= 1'b0;
            sweep_l   <= 1'b0;
            sweep_r   <= 1'b0;
            err_pulse <= 1'b0;
        end else begin
            cnt_l     <= cnt_nxt_l;
            cnt_r     <= cnt_nxt_r;
            err_l     <= err_nxt_l;
            err_r     <= err_nxt_r;
            sweep_l   <= ev_sweep_l;
            sweep_r   <= ev_sweep_r;
            err_pulse <= ev_err_l | ev_err_r;
            if (sample) begin
                state_l <= trk_l[3:2];
                state_r <= trk_r[3:2];
                // Raw activity, so an illegal nonzero code still counts.
                mode    <= {(lamp_r != 3'b000), (lamp_l != 3'b000)};
            end
        end
    end

    assign pos_l = state_l;
    assign pos_r = state_r;

endmodule

// File: tb/tb_thunderbird_lamp_monitor.sv
module tb_thunderbird_lamp_monitor;

  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             sample = 1'b0;
  logic             clr = 1'b0;
  logic [2:0]       lamp_l = 3'b000;
  logic [2:0]       lamp_r = 3'b000;
  logic [1:0]       pos_l, pos_r, mode;
  logic             sweep_l, sweep_r, err_l, err_r, err_pulse;
  logic [CNT_W-1:0] cnt_l, cnt_r;

  always #5 clk = ~clk;

  thunderbird_lamp_monitor #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .sample(sample), .clr(clr),
    .lamp_l(lamp_l), .lamp_r(lamp_r),
    .pos_l(pos_l), .pos_r(pos_r), .mode(mode),
    .sweep_l(sweep_l), .sweep_r(sweep_r),
    .cnt_l(cnt_l), .cnt_r(cnt_r),
    .err_l(err_l), .err_r(err_r), .err_pulse(err_pulse)
  );

  // ---------------- reference model ----------------
  // Positions are indices into the lamp code tables; a sweep is any
  // return to index 0 from index 3 along the legal path.
  int tbl_l[4] = '{0, 1, 3, 7};
  int tbl_r[4] = '{0, 4, 6, 7};

  int m_pos_l, m_pos_r, m_cnt_l, m_cnt_r, m_mode;
  bit m_err_l, m_err_r, m_sw_l, m_sw_r, m_ep;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic model_reset();
    m_pos_l = 0; m_pos_r = 0; m_cnt_l = 0; m_cnt_r = 0; m_mode = 0;
    m_err_l = 0; m_err_r = 0; m_sw_l = 0; m_sw_r = 0; m_ep = 0;
  endtask

  task automatic bank_step(input logic [2:0] code, input bit left, input int pos,
                           output int npos, output bit sw, output bit er);
    int n;
    n = -1;
    for (int i = 0; i < 4; i++)
      if (int'(code) == (left ? tbl_l[i] : tbl_r[i])) n = i;
    sw = 0; er = 0; npos = pos;
    if (n < 0) begin
      er = 1; npos = 0;
    end else if (n == 0) begin
      npos = 0; sw = (pos == 3);
    end else if (n == pos + 1) begin
      npos = n;
    end else begin
      er = 1; npos = n;
    end
  endtask

  task automatic model_edge(input bit s, input bit c,
                            input logic [2:0] l, input logic [2:0] r);
    int  npl, npr;
    bit  swl, swr, el, er;
    if (c) begin
      m_cnt_l = 0; m_cnt_r = 0; m_err_l = 0; m_err_r = 0;
    end
    m_sw_l = 0; m_sw_r = 0; m_ep = 0;
    if (s) begin
      bank_step(l, 1'b1, m_pos_l, npl, swl, el);
      bank_step(r, 1'b0, m_pos_r, npr, swr, er);
      m_pos_l = npl; m_pos_r = npr;
      if (swl && m_cnt_l < CNT_MAX) m_cnt_l++;
      if (swr && m_cnt_r < CNT_MAX) m_cnt_r++;
      m_err_l = m_err_l | el;
      m_err_r = m_err_r | er;
      m_sw_l = swl; m_sw_r = swr; m_ep = el | er;
      m_mode = (r != 3'b000 ? 2 : 0) + (l != 3'b000 ? 1 : 0);
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ph);
    chk({ph, ".pos_l"},     8'(pos_l),     8'(m_pos_l));
    chk({ph, ".pos_r"},     8'(pos_r),     8'(m_pos_r));
    chk({ph, ".mode"},      8'(mode),      8'(m_mode));
    chk({ph, ".sweep_l"},   8'(sweep_l),   8'(m_sw_l));
    chk({ph, ".sweep_r"},   8'(sweep_r),   8'(m_sw_r));
    chk({ph, ".cnt_l"},     8'(cnt_l),     8'(m_cnt_l));
    chk({ph, ".cnt_r"},     8'(cnt_r),     8'(m_cnt_r));
    chk({ph, ".err_l"},     8'(err_l),     8'(m_err_l));
    chk({ph, ".err_r"},     8'(err_r),     8'(m_err_r));
    chk({ph, ".err_pulse"}, 8'(err_pulse), 8'(m_ep));
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input string ph, input bit s, input bit c,
                       input logic [2:0] l, input logic [2:0] r);
    @(negedge clk);
    sample = s; clr = c; lamp_l = l; lamp_r = r;
    @(posedge clk);
    model_edge(s, c, l, r);
    #1;
    check_all(ph);
  endtask

  // Reset asserted between edges: outputs must clear without a clock edge.
  task automatic async_reset(input string ph);
    @(negedge clk);
    sample = 0; clr = 0;
    #2 rst = 1;
    #1;
    model_reset();
    check_all(ph);
    @(negedge clk);
    rst = 0;
  endtask

  task automatic left_seq(input string ph, input int n, input int codes[8]);
    for (int i = 0; i < n; i++) cycle(ph, 1, 0, 3'(codes[i]), 3'b000);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int seq[8];
    model_reset();
    #2;
    check_all("reset_hold");
    @(negedge clk);
    rst = 0;

    // Basic left sweep
    seq = '{0, 1, 3, 7, 0, 0, 0, 0};
    left_seq("left_sweep", 5, seq);
    chk("left_sweep.cnt_final", 8'(cnt_l), 8'd1);
    cycle("idle_after", 0, 0, 3'b000, 3'b000);

    // Hazard, two lockstep sweeps from cleared counters
    cycle("hz_clr", 0, 1, 3'b000, 3'b000);
    for (int k = 0; k < 2; k++) begin
      cycle("hazard", 1, 0, 3'b001, 3'b100);
      chk("hazard.mode11", 8'(mode), 8'd3);
      cycle("hazard", 1, 0, 3'b011, 3'b110);
      cycle("hazard", 1, 0, 3'b111, 3'b111);
      cycle("hazard", 1, 0, 3'b000, 3'b000);
    end
    chk("hazard.cnt_l", 8'(cnt_l), 8'd2);
    chk("hazard.cnt_r", 8'(cnt_r), 8'd2);

    // Abort then hold
    seq = '{1, 3, 0, 1, 1, 0, 0, 0};
    left_seq("abort_hold", 5, seq);
    chk("hold.err_l", 8'(err_l), 8'd1);
    cycle("hold_after", 0, 0, 3'b000, 3'b000);

    // Illegal right code, then resume
    cycle("ill_r", 1, 0, 3'b000, 3'b100);
    cycle("ill_r", 1, 0, 3'b000, 3'b010);
    chk("ill_r.pos_r", 8'(pos_r), 8'd0);
    cycle("ill_r", 1, 0, 3'b000, 3'b100);
    cycle("ill_r", 0, 0, 3'b000, 3'b000);
    chk("ill_r.sticky", 8'(err_r), 8'd1);

    // Saturation: five left sweeps
    cycle("sat_clr", 0, 1, 3'b000, 3'b000);
    for (int k = 0; k < 5; k++) begin
      seq = '{1, 3, 7, 0, 0, 0, 0, 0};
      left_seq("sat", 4, seq);
    end
    chk("sat.cnt_l", 8'(cnt_l), 8'(CNT_MAX));

    // Reset mid-sweep, then clear coinciding with a completing sample
    seq = '{1, 3, 0, 0, 0, 0, 0, 0};
    left_seq("mid", 2, seq);
    async_reset("mid_rst");
    seq = '{1, 3, 7, 0, 0, 0, 0, 0};
    left_seq("post_rst", 3, seq);
    cycle("clr_sample", 1, 1, 3'b000, 3'b000);
    chk("clr_sample.cnt_l", 8'(cnt_l), 8'd1);
    chk("clr_sample.err_l", 8'(err_l), 8'd0);

    // Randomized traffic: biased toward the next legal code
    for (int i = 0; i < 400; i++) begin
      logic [2:0] l, r;
      bit         s, c;
      int         pick;
      s = ($urandom_range(0, 99) < 75);
      c = ($urandom_range(0, 99) < 5);
      pick = $urandom_range(0, 99);
      l = (pick < 70) ? 3'(tbl_l[(m_pos_l + 1) % 4]) :
          (pick < 85) ? 3'b000 : 3'($urandom_range(0, 7));
      pick = $urandom_range(0, 99);
      r = (pick < 70) ? 3'(tbl_r[(m_pos_r + 1) % 4]) :
          (pick < 85) ? 3'b000 : 3'($urandom_range(0, 7));
      if ($urandom_range(0, 199) == 0) async_reset("rand_rst");
      else cycle("rand", s, c, l, r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Watchdog: the run must never hang.
  initial begin
    #200000;
    n_miss++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/thunderbird_lamp_monitor.md
# thunderbird_lamp_monitor

Receive-side checker for the Thunderbird tail-lamp sequencer outputs. It samples the left and right 3-lamp banks on a sample strobe and tracks each bank's position in its 4-step sweep. It counts completed sweeps, decodes the signalling mode (idle, left, right, hazard) and flags any pattern or transition the sequencer can never legally produce. It sits beside the two lamp sequencers for in-system self-check and serves as a bench scoreboard.

## Interface
- CNT_W, 8, width of each sweep counter (saturating)
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- sample  input  1  evaluate lamp inputs this cycle; otherwise all state holds
- clr  input  1  synchronous clear of sweep counters and sticky error flags
- lamp_l  input  3  left bank; legal codes 000, 001, 011, 111 = positions 0..3
- lamp_r  input  3  right bank; legal codes 000, 100, 110, 111 = positions 0..3
- pos_l, pos_r  output  2  last accepted position per bank
- mode  output  2  00 idle, 01 left, 10 right, 11 hazard (both banks nonzero)
- sweep_l, sweep_r  output  1  one-cycle pulse on completed sweep (position 3 -> 0)
- cnt_l, cnt_r  output  CNT_W  completed-sweep counters
- err_l, err_r  output  1  sticky error flags
- err_pulse  output  1  one-cycle pulse on any new error on either bank

## Operation
- Each bank has an independent tracker FSM with states P0..P3, one per position.
- On a cycle with sample=1, each tracker decodes its bank code:
  - Legal code at position n: the transition from current state k is legal if n=0 (enable dropped, from any k), or n=k+1 for k<3. The FSM moves to Pn.
  - P3 -> P0 is a completed sweep: assert sweep_x and increment cnt_x, saturating at 2^CNT_W-1.
  - Other k -> 0 transitions are legal aborts. No sweep, no error.
  - Hold at a nonzero position (Pk with k>0 on consecutive samples) is illegal.
  - Skip, or backward move other than to 0, is illegal.
  - Illegal transition with a legal code: set err_x, pulse err_pulse, and resync the FSM to Pn. No sweep is counted even if k=3.
  - Illegal code (left 010/100/101/110, right 001/010/011/101): set err_x, pulse err_pulse, and force the FSM to P0.
- mode updates on sample from the raw codes: bit0 = (lamp_l != 000), bit1 = (lamp_r != 000). An illegal nonzero code still counts as active.
- pos_x = encoded FSM state.
- clr: counters go to 0 and err_l/err_r go to 0. If sample is also 1 in the same cycle, that sample's events are applied after the clear: counter ends at 1 if a sweep occurs, and the error flag ends at 1 if an error occurs.
- sample=0: FSMs, mode, counters and flags hold. Pulses are 0. clr still acts.

## Timing
- All outputs are registered. Effects of a sample at edge N are visible after edge N, one cycle of latency.
- sweep_x and err_pulse are high for exactly the cycle following the sampling edge.
- Both banks are evaluated in the same cycle. err_pulse is a single pulse even if both banks err together.
- Reset (asynchronous, any time, including mid-sweep) sets:
  - both FSMs to P0
  - pos 00, mode 00
  - cnt 0
  - err_l/err_r 0
  - all pulses 0
- After reset deassertion, the first sample is judged from P0. For example, code 011 first is a skip error.
- Counter saturation: at all-ones, further sweeps still pulse sweep_x but cnt_x holds.

## Test plan
- Reset, then left samples 000,001,011,111,000 -> pos_l 0,1,2,3,0; sweep_l pulses once after the fifth sample; cnt_l=1; err_l=0; mode 01 during 001..111, then 00.
- Hazard: both banks stepped in lockstep for two full sweeps -> mode=11 while nonzero; sweep_l and sweep_r pulse in the same cycles; cnt_l=cnt_r=2; no errors.
- Abort and hold: left 001,011,000 -> no sweep, no error. Left 001,001 -> err_l=1, err_pulse one cycle, pos_l=1.
- Illegal code: right 100, then 010 -> err_r=1, pos_r=0. Next sample 100 is accepted with no new err_pulse. err_r stays 1 until clr.
- Saturation with CNT_W=2: left completes 5 sweeps -> cnt_l reaches 3 and holds; sweep_l pulses 5 times.
- Reset mid-sweep at left P2, then clr together with a sample: assert rst -> all outputs 0 immediately. Then drive left P3 and sample 000 in the same cycle as clr=1 -> cnt_l=1, err_l=0.
